mem_slot_scheduler: RTL and testbench

Time-slot memory scheduler sharing the BIOS ROM, common RAM and text video RAM write/read port between the CPU and one DMA requester. Each 100 MHz clock is split into a 4-phase cycle: two phases for the CPU bus, two for DMA. The block generates the gated 25 MHz CPU clock, decodes the memory map, drives the memory address, write-data and write-enable lines, and registers read data back to each master.

---
 rtl/mem_slot_scheduler.sv | 173 +++++++++++++++++
 tb/tb_mem_slot_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slot_scheduler.sv
// Four-phase time-slot scheduler sharing ROM, common RAM and video RAM between the CPU
// (phases 0-1) and a single DMA requester (phases 2-3); also generates the gated CPU clock.
module mem_slot_scheduler #(
  parameter int PHASE_W = 2,
  parameter bit DMA_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        cpu_clk,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_o,
  input  logic        cpu_w,
  output logic [7:0]  cpu_i,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  rom_q,
  input  logic [7:0]  ram_q,
  input  logic [7:0]  vid_q,
  output logic        ram_wren,
  output logic        vid_wren
);

  localparam logic [PHASE_W-1:0] PH0 = 2'd0;
  localparam logic [PHASE_W-1:0] PH1 = 2'd1;
  localparam logic [PHASE_W-1:0] PH2 = 2'd2;
  localparam logic [PHASE_W-1:0] PH3 = 2'd3;

  localparam logic [1:0] REG_NONE = 2'd0;
  localparam logic [1:0] REG_ROM  = 2'd1;
  localparam logic [1:0] REG_RAM  = 2'd2;
  localparam logic [1:0] REG_VID  = 2'd3;

  function automatic logic [1:0] region_of(input logic [15:0] a);
    logic [1:0] r;
    if (a[15:13] == 3'b111) begin
      r = REG_ROM;
    end else if (a[15:14] == 2'b00) begin
      r = REG_RAM;
    end else if (a[15:12] == 4'hB) begin
      r = REG_VID;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] phase_nxt_s;
  logic               started_r;
  logic               started_nxt_s;
  logic               cpu_clk_r;
  logic               cpu_we_r;
  logic               dma_we_r;
  logic               grant_r;
  logic [1:0]         region_r;
  logic [15:0]        mem_addr_r;
  logic [7:0]         mem_wdata_r;
  logic [7:0]         cpu_i_r;
  logic [7:0]         dma_rdata_r;
  logic               dma_ack_r;
  logic               dma_rvalid_r;
  logic               ram_wren_r;
  logic               vid_wren_r;
  logic               dma_take_s;
  logic               wr_slot_s;
  logic [7:0]         q_sel_s;

  assign phase_nxt_s   = phase_r + 2'd1;
  assign started_nxt_s = started_r | (phase_r == PH3);
  assign dma_take_s    = DMA_EN & dma_req;
  // region_r always describes whichever master currently owns mem_addr
  assign wr_slot_s     = ((phase_r == PH0) && cpu_we_r) ||
                         ((phase_r == PH2) && grant_r && dma_we_r);

  // Read-data mux; unmapped addresses read as zero
  always_comb begin
    q_sel_s = 8'h00;
    case (region_r)
      REG_ROM: q_sel_s = rom_q;
      REG_RAM: q_sel_s = ram_q;
      REG_VID: q_sel_s = vid_q;
      default: q_sel_s = 8'h00;
    endcase
  end

  // Phase counter, start flag and gated CPU clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r   <= PH0;
      started_r <= 1'b0;
      cpu_clk_r <= 1'b0;
    end else begin
      phase_r   <= phase_nxt_s;
      started_r <= started_nxt_s;
      cpu_clk_r <= started_nxt_s & phase_nxt_s[1];
    end
  end

  // Address/data path: CPU owns the bus from phase 0, a granted DMA from phase 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 8'h00;
      region_r    <= REG_NONE;
      cpu_we_r    <= 1'b0;
      dma_we_r    <= 1'b0;
      grant_r     <= 1'b0;
      dma_ack_r   <= 1'b0;
    end else begin
      dma_ack_r <= (phase_r == PH1) && dma_take_s;
      if (phase_r == PH3) begin
        mem_addr_r  <= cpu_a;
        mem_wdata_r <= cpu_o;
        region_r    <= region_of(cpu_a);
        cpu_we_r    <= cpu_w;
      end else if (phase_r == PH1) begin
        grant_r <= dma_take_s;
        if (dma_take_s) begin
          mem_addr_r  <= dma_addr;
          mem_wdata_r <= dma_wdata;
          region_r    <= region_of(dma_addr);
          dma_we_r    <= dma_we;
        end
      end
    end
  end

  // One-clock write strobes in phase 1 (CPU) or phase 3 (DMA), writable regions only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_wren_r <= 1'b0;
      vid_wren_r <= 1'b0;
    end else begin
      ram_wren_r <= wr_slot_s && (region_r == REG_RAM);
      vid_wren_r <= wr_slot_s && (region_r == REG_VID);
    end
  end

  // Read-data capture at the end of each master's second phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_i_r      <= 8'h00;
      dma_rdata_r  <= 8'h00;
      dma_rvalid_r <= 1'b0;
    end else begin
      dma_rvalid_r <= (phase_r == PH3) && grant_r && !dma_we_r;
      if (phase_r == PH1) begin
        cpu_i_r <= q_sel_s;
      end
      if ((phase_r == PH3) && grant_r && !dma_we_r) begin
        dma_rdata_r <= q_sel_s;
      end
    end
  end

  assign cpu_clk    = cpu_clk_r;
  assign cpu_i      = cpu_i_r;
  assign dma_ack    = dma_ack_r;
  assign dma_rdata  = dma_rdata_r;
  assign dma_rvalid = dma_rvalid_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign ram_wren   = ram_wren_r;
  assign vid_wren   = vid_wren_r;

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Bench for mem_slot_scheduler: directed cases plus randomized CPU/DMA traffic checked
// against a memory-map shadow model; a second instance has DMA disabled.
module tb_mem_slot_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic [7:0]  rom_q, ram_q, vid_q;

  logic        cpu_clk, dma_ack, dma_rvalid, ram_wren, vid_wren;
  logic [7:0]  cpu_i, dma_rdata, mem_wdata;
  logic [15:0] mem_addr;

  logic        cpu_clk_z, dma_ack_z, dma_rvalid_z, ram_wren_z, vid_wren_z;
  logic [7:0]  cpu_i_z, dma_rdata_z, mem_wdata_z;
  logic [15:0] mem_addr_z;

  logic [7:0] rom [0:8191];
  logic [7:0] ram [0:16383];
  logic [7:0] vid [0:4095];
  logic [7:0] exp_ram [0:16383];
  logic [7:0] exp_vid [0:4095];

  int k;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic        prev_dv, prev_dwe, prev_cr;
  logic [15:0] prev_da;
  logic [7:0]  prev_dd, prev_cexp;

  always #5 clk = ~clk;

  mem_slot_scheduler #(.PHASE_W(2), .DMA_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_clk(cpu_clk), .cpu_a(cpu_a), .cpu_o(cpu_o),
    .cpu_w(cpu_w), .cpu_i(cpu_i), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rom_q(rom_q), .ram_q(ram_q), .vid_q(vid_q), .ram_wren(ram_wren), .vid_wren(vid_wren)
  );

  mem_slot_scheduler #(.PHASE_W(2), .DMA_EN(1'b0)) dut_nodma (
    .clk(clk), .reset_n(reset_n), .cpu_clk(cpu_clk_z), .cpu_a(cpu_a), .cpu_o(cpu_o),
    .cpu_w(cpu_w), .cpu_i(cpu_i_z), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_ack(dma_ack_z), .dma_rdata(dma_rdata_z),
    .dma_rvalid(dma_rvalid_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
    .rom_q(rom_q), .ram_q(ram_q), .vid_q(vid_q), .ram_wren(ram_wren_z), .vid_wren(vid_wren_z)
  );

  // Physical memories with one-clock read latency, driven by the main instance
  always @(posedge clk) begin
    if (ram_wren) ram[mem_addr[13:0]] <= mem_wdata;
    if (vid_wren) vid[mem_addr[11:0]] <= mem_wdata;
    rom_q <= rom[mem_addr[12:0]];
    ram_q <= ram[mem_addr[13:0]];
    vid_q <= vid[mem_addr[11:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // 0 unmapped, 1 ROM, 2 RAM, 3 VRAM
  function automatic int region(input logic [15:0] a);
    if (a >= 16'hE000) return 1;
    if (a < 16'h4000) return 2;
    if (a >= 16'hB000 && a < 16'hC000) return 3;
    return 0;
  endfunction

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    case (region(a))
      1: return rom[int'(a) - 'hE000];
      2: return exp_ram[int'(a)];
      3: return exp_vid[int'(a) - 'hB000];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (region(a) == 2) exp_ram[int'(a)] = d;
    else if (region(a) == 3) exp_vid[int'(a) - 'hB000] = d;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cpu_clk"}, 16'(cpu_clk), 16'h0000);
    chk({tag, "_cpu_i"}, 16'(cpu_i), 16'h0000);
    chk({tag, "_dma_rdata"}, 16'(dma_rdata), 16'h0000);
    chk({tag, "_ack_rvalid"}, 16'({dma_ack, dma_rvalid}), 16'h0000);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_mem_wdata"}, 16'(mem_wdata), 16'h0000);
    chk({tag, "_wrens"}, 16'({ram_wren, vid_wren}), 16'h0000);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 15));
      1: return 16'hB000 + 16'($urandom_range(0, 15));
      2: return 16'hE000 + 16'($urandom_range(0, 8191));
      default: return 16'h4000 + 16'($urandom_range(0, 16'h6FFF));
    endcase
  endfunction

  // One CPU bus cycle (and optional DMA request) starting in phase 2
  task automatic iter(input logic [15:0] ca, input logic [7:0] co, input logic cw,
                      input logic dv, input logic [15:0] da, input logic [7:0] dd,
                      input logic dwe);
    cpu_a = ca; cpu_o = co; cpu_w = cw;
    dma_req = dv; dma_addr = da; dma_wdata = dd; dma_we = dwe;
    tick();  // phase 3: previous DMA write strobe
    chk("ph3_ram_wren", 16'(ram_wren), 16'(prev_dv && prev_dwe && region(prev_da) == 2));
    chk("ph3_vid_wren", 16'(vid_wren), 16'(prev_dv && prev_dwe && region(prev_da) == 3));
    chk("ph3_ack", 16'(dma_ack), 16'h0000);
    chk("ph3_cpu_clk", 16'(cpu_clk), 16'h0001);
    if (prev_dv && prev_dwe) model_write(prev_da, prev_dd);
    tick();  // phase 0: previous DMA read data, CPU address out
    chk("ph0_rvalid", 16'(dma_rvalid), 16'(prev_dv && !prev_dwe));
    if (prev_dv && !prev_dwe) chk("ph0_dma_rdata", 16'(dma_rdata), 16'(exp_read(prev_da)));
    if (prev_cr) chk("ph0_cpu_i_hold", 16'(cpu_i), 16'(prev_cexp));
    chk("ph0_mem_addr", mem_addr, ca);
    chk("ph0_mem_wdata", 16'(mem_wdata), 16'(co));
    chk("ph0_wrens", 16'({ram_wren, vid_wren}), 16'h0000);
    chk("ph0_cpu_clk", 16'(cpu_clk), 16'h0000);
    tick();  // phase 1: CPU write strobe
    chk("ph1_ram_wren", 16'(ram_wren), 16'(cw && region(ca) == 2));
    chk("ph1_vid_wren", 16'(vid_wren), 16'(cw && region(ca) == 3));
    chk("ph1_rvalid", 16'(dma_rvalid), 16'h0000);
    if (cw) model_write(ca, co);
    tick();  // phase 2: CPU read data, DMA grant
    if (!cw) chk("ph2_cpu_i", 16'(cpu_i), 16'(exp_read(ca)));
    chk("ph2_ack", 16'(dma_ack), 16'(dv));
    chk("ph2_ack_nodma", 16'(dma_ack_z), 16'h0000);
    chk("ph2_mem_addr", mem_addr, dv ? da : ca);
    if (dv) chk("ph2_mem_wdata", 16'(mem_wdata), 16'(dd));
    chk("ph2_wrens", 16'({ram_wren, vid_wren}), 16'h0000);
    dma_req = 1'b0;
    prev_dv = dv; prev_da = da; prev_dd = dd; prev_dwe = dwe;
    prev_cr = !cw; prev_cexp = exp_read(ca);
  endtask

  initial begin
    logic [15:0] ra, rd;
    logic [7:0]  bdata [0:2];
    reset_n = 1'b0; k = 0;
    cpu_a = 16'h0000; cpu_o = 8'h00; cpu_w = 1'b0;
    dma_req = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00; dma_we = 1'b0;
    prev_dv = 1'b0; prev_dwe = 1'b0; prev_cr = 1'b0;
    prev_da = 16'h0000; prev_dd = 8'h00; prev_cexp = 8'h00;
    for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 16384; i++) begin ram[i] = 8'($urandom); exp_ram[i] = ram[i]; end
    for (int i = 0; i < 4096; i++) begin vid[i] = 8'($urandom); exp_vid[i] = vid[i]; end
    rom[0] = 8'hC3;
    ram[0] = 8'h00;       exp_ram[0] = 8'h00;
    ram['h100] = 8'h77;   exp_ram['h100] = 8'h77;

    repeat (3) tick();
    chk_reset_state("rst");
    reset_n = 1'b1;
    k = 0;

    // Idle after reset: CPU clock starts in the 7th clk, everything else quiet
    for (int i = 0; i < 12; i++) begin
      chk("idle_cpu_clk", 16'(cpu_clk), 16'((k >= 4) && (k % 4 >= 2)));
      chk("idle_cpu_i", 16'(cpu_i), 16'h0000);
      chk("idle_mem_addr", mem_addr, 16'h0000);
      chk("idle_quiet", 16'({ram_wren, vid_wren, dma_ack, dma_rvalid}), 16'h0000);
      tick();
    end
    while (k % 4 != 2) tick();

    iter(16'h1234, 8'h5A, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'hB010, 8'hA5, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'hE000, 8'h11, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'hE000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'h8000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'hE000, 8'h00, 1'b0, 1'b1, 16'h0100, 8'h00, 1'b0);
    iter(16'h1234, 8'h00, 1'b0, 1'b1, 16'h0200, 8'h3C, 1'b1);
    iter(16'h0200, 8'h00, 1'b0, 1'b1, 16'hE001, 8'h99, 1'b1);
    iter(16'hB010, 8'h00, 1'b0, 1'b1, 16'h9000, 8'h00, 1'b0);

    for (int i = 0; i < 48; i++) begin
      ra = rand_addr();
      rd = rand_addr();
      iter(ra, 8'($urandom), 1'($urandom), 1'($urandom), rd, 8'($urandom), 1'($urandom));
    end
    iter(16'h8000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Back-to-back DMA writes with dma_req held high
    cpu_a = 16'h8000; cpu_w = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bdata[j] = 8'($urandom);
      dma_addr = 16'hB100 + 16'(j);
      dma_wdata = bdata[j];
      for (int t = 1; t <= 4; t++) begin
        tick();
        chk("b2b_ack", 16'(dma_ack), 16'(t == 4));
        chk("b2b_ack_nodma", 16'(dma_ack_z), 16'h0000);
        chk("b2b_vid_wren", 16'(vid_wren), 16'(t == 1 && j > 0));
        chk("b2b_ram_wren", 16'(ram_wren), 16'h0000);
        if (t == 1 && j > 0) model_write(16'hB100 + 16'(j - 1), bdata[j - 1]);
      end
    end
    dma_req = 1'b0;
    tick();
    chk("b2b_last_vid_wren", 16'(vid_wren), 16'h0001);
    model_write(16'hB102, bdata[2]);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("b2b_after_ack", 16'(dma_ack), 16'h0000);
      chk("b2b_after_wren", 16'({ram_wren, vid_wren}), 16'h0000);
    end
    while (k % 4 != 2) tick();
    prev_dv = 1'b0; prev_cr = 1'b0;
    iter(16'hB100, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'hB101, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    iter(16'hB102, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Reset asserted in phase 3 of a granted DMA read
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100;
    repeat (4) tick();
    chk("rstdma_ack", 16'(dma_ack), 16'h0001);
    dma_req = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1 chk_reset_state("rst_mid");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_hold_rvalid", 16'(dma_rvalid), 16'h0000);
    end
    reset_n = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_after_rvalid", 16'(dma_rvalid), 16'h0000);
      chk("rst_after_cpu_clk", 16'(cpu_clk), 16'((k >= 4) && (k % 4 >= 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
